serial_slave_mem: RTL and testbench

SERIAL_SLAVE_MEM -- requirements
Module: serial_slave_mem

---
 rtl/serial_slave_mem.sv | 231 +++++++++++++++++++++++
 tb/tb_serial_slave_mem.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_mem.sv
// serial_slave_mem: single-wire serial bus slave in front of a 2**ADDR_W x DATA_W memory.
// Frames are a start bit, ADDR_W address bits and then a burst of DATA_W-bit words, all sent LSB first.
// B_SEL held high at the end of a word continues the burst at the next address, which wraps.
// Optional build macro SERIAL_SLAVE_PARITY_EN adds one even-parity bit after every data word.
module serial_slave_mem #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              B_SEL,
  input  logic              B_RW,
  input  logic              B_BUS_OUT,
  output logic              B_BUS_IN,
  output logic              B_ACK,
  output logic              B_SBSY,
  output logic              S_DVALID,
  output logic [DATA_W-1:0] S_DOUT
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = (MAX_W > 2) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StWcommit,
    StRack,
`ifdef SERIAL_SLAVE_PARITY_EN
    StRdata,
    StPar
`else
    StRdata
`endif
  } state_e;

  state_e            state_q;
  logic              rw_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-2:0] wbuf_q;    // first DATA_W-1 write bits; the last bit joins from the line
  logic [DATA_W-1:0] rshift_q;  // read bits still to be driven
`ifdef SERIAL_SLAVE_PARITY_EN
  logic [DATA_W-1:0] pword_q;   // complete write word held while its parity bit arrives
  logic              rpar_q;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] wword;
  logic [DATA_W-1:0] commit_word;
  logic              commit;

  assign mem_rdata = mem[addr_q];
  assign wword     = {B_BUS_OUT, wbuf_q};

`ifdef SERIAL_SLAVE_PARITY_EN
  // The write is committed when the parity bit matches the even parity of the word.
  assign commit      = (state_q == StPar) && rw_q && B_SEL && (B_BUS_OUT == ^pword_q);
  assign commit_word = pword_q;
`else
  // The write is committed together with the last data bit.
  assign commit      = (state_q == StWdata) && B_SEL && (cnt_q == DATA_LAST);
  assign commit_word = wword;
`endif

  // Memory array: written on commit and never cleared by reset.
  always_ff @(posedge CLK) begin
    if (commit) begin
      mem[addr_q] <= commit_word;
    end
  end

  // Bus protocol FSM; all bus and status outputs are registered here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      rw_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wbuf_q   <= '0;
      rshift_q <= '0;
`ifdef SERIAL_SLAVE_PARITY_EN
      pword_q  <= '0;
      rpar_q   <= 1'b0;
`endif
      B_BUS_IN <= 1'b0;
      B_ACK    <= 1'b0;
      B_SBSY   <= 1'b0;
      S_DVALID <= 1'b0;
      S_DOUT   <= '0;
    end else begin
      B_BUS_IN <= 1'b0;
      B_ACK    <= 1'b0;
      S_DVALID <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (B_SEL && B_BUS_OUT) begin
            state_q <= StAddr;
            rw_q    <= B_RW;
            cnt_q   <= '0;
            B_SBSY  <= 1'b1;
          end
        end

        StAddr: begin
          if (!B_SEL) begin
            state_q <= StIdle;
            B_SBSY  <= 1'b0;
          end else begin
            addr_q <= {B_BUS_OUT, addr_q[ADDR_W-1:1]};
            if (cnt_q == ADDR_LAST) begin
              cnt_q <= '0;
              if (rw_q) begin
                state_q <= StWdata;
              end else begin
                state_q <= StRack;
                B_ACK   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        StWdata: begin
          if (!B_SEL) begin
            state_q <= StIdle;
            B_SBSY  <= 1'b0;
          end else begin
            wbuf_q <= wword[DATA_W-1:1];
            if (cnt_q == DATA_LAST) begin
              cnt_q <= '0;
`ifdef SERIAL_SLAVE_PARITY_EN
              pword_q <= wword;
              state_q <= StPar;
`else
              state_q  <= StWcommit;
              B_ACK    <= 1'b1;
              S_DVALID <= 1'b1;
              S_DOUT   <= commit_word;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        // Word complete for writes: B_SEL decides between next burst word and idle.
        StWcommit: begin
          if (B_SEL) begin
            addr_q  <= addr_q + 1'b1;
            state_q <= StWdata;
          end else begin
            state_q <= StIdle;
            B_SBSY  <= 1'b0;
          end
        end

        StRack: begin
          if (!B_SEL) begin
            state_q <= StIdle;
            B_SBSY  <= 1'b0;
          end else begin
            rshift_q <= mem_rdata >> 1;
            B_BUS_IN <= mem_rdata[0];
`ifdef SERIAL_SLAVE_PARITY_EN
            rpar_q   <= ^mem_rdata;
`endif
            cnt_q    <= '0;
            state_q  <= StRdata;
          end
        end

        StRdata: begin
          if (!B_SEL) begin
            state_q <= StIdle;
            B_SBSY  <= 1'b0;
          end else if (cnt_q == DATA_LAST) begin
`ifdef SERIAL_SLAVE_PARITY_EN
            state_q  <= StPar;
            B_BUS_IN <= rpar_q;
`else
            addr_q  <= addr_q + 1'b1;
            state_q <= StRack;
            B_ACK   <= 1'b1;
`endif
          end else begin
            B_BUS_IN <= rshift_q[0];
            rshift_q <= rshift_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end

`ifdef SERIAL_SLAVE_PARITY_EN
        // Parity cycle: check the write parity, or end the read word.
        StPar: begin
          if (!B_SEL) begin
            state_q <= StIdle;
            B_SBSY  <= 1'b0;
          end else if (rw_q) begin
            if (commit) begin
              state_q  <= StWcommit;
              B_ACK    <= 1'b1;
              S_DVALID <= 1'b1;
              S_DOUT   <= commit_word;
            end else begin
              state_q <= StIdle;
              B_SBSY  <= 1'b0;
            end
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= StRack;
            B_ACK   <= 1'b1;
          end
        end
`endif

        default: begin
          state_q <= StIdle;
          B_SBSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slave_mem.sv
// Scoreboard bench for serial_slave_mem: the driver pushes the expected commits and read words into queues.
// A negedge monitor pops from those queues and compares whenever the DUT acknowledges.
module tb_serial_slave_mem;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          B_SEL = 1'b0;
  logic          B_RW = 1'b0;
  logic          B_BUS_OUT = 1'b0;
  logic          B_BUS_IN;
  logic          B_ACK;
  logic          B_SBSY;
  logic          S_DVALID;
  logic [DW-1:0] S_DOUT;

  int total = 0;
  int bad = 0;
  int acks_exp = 0;
  int acks_seen = 0;

  // Reference memory: contents plus a flag telling whether the word has ever been written.
  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] wr_q [$];
  logic [DW-1:0] rd_q [$];
  logic [DW-1:0] burst [8];

  serial_slave_mem #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .B_SEL    (B_SEL),
    .B_RW     (B_RW),
    .B_BUS_OUT(B_BUS_OUT),
    .B_BUS_IN (B_BUS_IN),
    .B_ACK    (B_ACK),
    .B_SBSY   (B_SBSY),
    .S_DVALID (S_DVALID),
    .S_DOUT   (S_DOUT)
  );

  always #5 CLK = ~CLK;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT acknowledges a word or drives read bits.
  int            rd_left = 0;
  int            mon_idx;
  logic [DW-1:0] rd_exp;
  always @(negedge CLK) begin
    if (RST) begin
      rd_left = 0;
    end else begin
      if (B_ACK) acks_seen++;
      if (S_DVALID) begin
        check("dvalid_has_ack", B_ACK, 1);
        check("write_expected", (wr_q.size() > 0), 1);
        if (wr_q.size() > 0) check("s_dout", S_DOUT, wr_q.pop_front());
      end else if (B_ACK) begin
        check("rack_bus_low", B_BUS_IN, 0);
        check("read_expected", (rd_q.size() > 0), 1);
        if (rd_q.size() > 0) begin
          rd_exp  = rd_q.pop_front();
          rd_left = DW + PB;
        end
      end else if (rd_left > 0) begin
        mon_idx = DW + PB - rd_left;
`ifdef SERIAL_SLAVE_PARITY_EN
        if (mon_idx == DW) check("read_parity", B_BUS_IN, ^rd_exp);
        else check("read_bit", B_BUS_IN, rd_exp[mon_idx]);
`else
        check("read_bit", B_BUS_IN, rd_exp[mon_idx]);
`endif
        rd_left--;
      end else begin
        check("bus_in_low", B_BUS_IN, 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_start(input bit rw, input int addr);
    B_SEL = 1'b1;
    B_BUS_OUT = 1'b1;
    B_RW = rw;
    tick();
    for (int i = 0; i < AW; i++) begin
      B_BUS_OUT = addr[i];
      B_RW = 1'($urandom);
      tick();
    end
  endtask

  task automatic write_burst(input int addr, input int n, input bit bad_par);
    logic [DW-1:0] d;
    send_start(1'b1, addr);
    for (int w = 0; w < n; w++) begin
      d = burst[w];
      if (!bad_par) begin
        wr_q.push_back(d);
        model[(addr + w) % DEPTH] = d;
        known[(addr + w) % DEPTH] = 1'b1;
        acks_exp++;
      end
      for (int i = 0; i < DW; i++) begin
        B_BUS_OUT = d[i];
        tick();
      end
`ifdef SERIAL_SLAVE_PARITY_EN
      B_BUS_OUT = (^d) ^ bad_par;
      tick();
      if (bad_par) begin
        B_SEL = 1'b0;
        B_BUS_OUT = 1'b0;
        tick();
        check("busy_after_bad_parity", B_SBSY, 0);
        return;
      end
`endif
      B_SEL = (w < n - 1);
      B_BUS_OUT = 1'($urandom);
      tick();
    end
    B_SEL = 1'b0;
    B_BUS_OUT = 1'b0;
    check("busy_after_write", B_SBSY, 0);
  endtask

  task automatic read_burst(input int addr, input int n);
    for (int w = 0; w < n; w++) begin
      rd_q.push_back(model[(addr + w) % DEPTH]);
      acks_exp++;
    end
    send_start(1'b0, addr);
    for (int w = 0; w < n; w++) begin
      B_SEL = 1'b1;
      B_BUS_OUT = 1'($urandom);
      tick();
      for (int i = 0; i < DW + PB; i++) begin
        B_SEL = (i == DW + PB - 1) ? (w < n - 1) : 1'b1;
        B_BUS_OUT = 1'($urandom);
        tick();
      end
    end
    B_SEL = 1'b0;
    B_BUS_OUT = 1'b0;
    check("busy_after_read", B_SBSY, 0);
  endtask

  // Idle traffic with no start bit must leave the slave idle.
  task automatic idle_noise(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      B_SEL = 1'($urandom);
      B_BUS_OUT = B_SEL ? 1'b0 : 1'($urandom);
      B_RW = 1'($urandom);
      tick();
      check("idle_noise_not_busy", B_SBSY, 0);
    end
    B_SEL = 1'b0;
    B_BUS_OUT = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a;
    int n;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_bus_in", B_BUS_IN, 0);
    check("rst_ack", B_ACK, 0);
    check("rst_busy", B_SBSY, 0);
    check("rst_dvalid", S_DVALID, 0);
    check("rst_dout", S_DOUT, 0);
    #2 RST = 1'b0;
    tick();

    // Single write then read back, bit pattern checked by the monitor
    burst[0] = 8'hA5;
    write_burst(11'h005, 1, 1'b0);
    check("dout_after_write", S_DOUT, 8'hA5);
    idle_noise(3);
    read_burst(11'h005, 1);

    // Burst across the top of the address space
    burst[0] = 8'h11;
    burst[1] = 8'h22;
    write_burst(11'h7FF, 2, 1'b0);
    read_burst(11'h7FF, 2);
    read_burst(11'h000, 1);

    // Abort after three data bits must leave the old value
    burst[0] = 8'h3C;
    write_burst(11'h010, 1, 1'b0);
    send_start(1'b1, 11'h010);
    for (int i = 0; i < 3; i++) begin
      B_BUS_OUT = 1'($urandom);
      tick();
    end
    B_SEL = 1'b0;
    tick();
    check("busy_after_abort", B_SBSY, 0);
    tick();
    read_burst(11'h010, 1);

    // Asynchronous reset in the middle of the address phase
    B_SEL = 1'b1;
    B_BUS_OUT = 1'b1;
    B_RW = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      B_BUS_OUT = 1'($urandom);
      tick();
    end
    check("busy_mid_addr", B_SBSY, 1);
    #2 RST = 1'b1;
    B_SEL = 1'b0;
    B_BUS_OUT = 1'b0;
    #1;
    check("async_rst_busy", B_SBSY, 0);
    check("async_rst_dout", S_DOUT, 0);
    check("async_rst_ack", B_ACK, 0);
    check("async_rst_bus_in", B_BUS_IN, 0);
    @(posedge CLK);
    #3 RST = 1'b0;
    tick();
    burst[0] = 8'h5A;
    write_burst(11'h123, 1, 1'b0);
    read_burst(11'h123, 1);
    read_burst(11'h010, 1);

`ifdef SERIAL_SLAVE_PARITY_EN
    burst[0] = 8'h77;
    write_burst(11'h040, 1, 1'b0);
    burst[0] = 8'h03;
    write_burst(11'h040, 1, 1'b1);
    read_burst(11'h040, 1);
    write_burst(11'h040, 1, 1'b0);
    read_burst(11'h040, 1);
`endif

    // Randomized bursts, each optionally read back
    for (int t = 0; t < 25; t++) begin
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 4) == 0) a = DEPTH - 1 - $urandom_range(0, 1);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) burst[k] = 8'($urandom);
      write_burst(a, n, 1'b0);
      idle_noise($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) read_burst(a, n);
      idle_noise($urandom_range(0, 2));
    end

    repeat (3) tick();
    check("write_queue_drained", wr_q.size(), 0);
    check("read_queue_drained", rd_q.size(), 0);
    check("ack_count", acks_seen, acks_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
